// File: rtl/sfp_pkg.sv
// Shared constants for the sfp_row sequencer: FSM encodings and sfp_row instructions.
package sfp_pkg;

  // Default pass size; also the depth of the sfp_row sum FIFO.
  localparam int ROWS_MAX = 16;

  // Sequencer states, kept as plain constants so legacy code can compare against them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ACC   = 3'd1;
  localparam state_t ST_XCHG  = 3'd2;
  localparam state_t ST_DIV   = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;

  // sfp_row instruction encodings; acc and div are one-hot and never combined.
  localparam logic [1:0] SFP_NOP = 2'b00;
  localparam logic [1:0] SFP_ACC = 2'b01;
  localparam logic [1:0] SFP_DIV = 2'b10;

endpackage

// File: rtl/sfp_lat_pipe.sv
// Strobe + address delay line matching a fixed read/compute latency.
module sfp_lat_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              strobe,
  input  logic [ADDR_W-1:0] addr,
  output logic              strobe_dly,
  output logic [ADDR_W-1:0] addr_dly
);

  logic [DEPTH-1:0]  strobe_reg;
  logic [ADDR_W-1:0] addr_reg [DEPTH];

  // Shift strobe and its address together so the address stays aligned with its strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      strobe_reg <= '0;
      for (int i = 0; i < DEPTH; i++) addr_reg[i] <= '0;
    end else begin
      strobe_reg[0] <= strobe;
      addr_reg[0]   <= addr;
      for (int i = 1; i < DEPTH; i++) begin
        strobe_reg[i] <= strobe_reg[i-1];
        addr_reg[i]   <= addr_reg[i-1];
      end
    end
  end

  assign strobe_dly = strobe_reg[DEPTH-1];
  assign addr_dly   = addr_reg[DEPTH-1];

endmodule

// File: rtl/sfp_seq_ctrl.sv
// Per-core sequencer for sfp_row: ACC pass over ofifo rows, peer sum exchange,
// DIV replay from psum memory into the output memory.
import sfp_pkg::*;

module sfp_seq_ctrl #(
  parameter int ROWS_MAX = sfp_pkg::ROWS_MAX,
  parameter int ROW_W    = 5,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              ofifo_valid,
  output logic              ofifo_rd,
  input  logic              peer_sum_valid,
  output logic              wr_sum,
  output logic [1:0]        sfp_inst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [ROW_W-1:0] ROWS_CAP = ROW_W'(ROWS_MAX);

  state_t             state_reg, state_next;
  logic [ROW_W-1:0]   rows_reg;
  logic [ROW_W-1:0]   rd_cnt_reg;
  logic [ROW_W-1:0]   acc_cnt_reg;
  logic [ROW_W-1:0]   peer_cnt_reg;
  logic [ADDR_W-1:0]  div_cnt_reg;
  logic               zero_done_reg;

  logic               acc_v;
  logic [ADDR_W-1:0]  acc_idx;
  logic               div_v;
  logic [ADDR_W-1:0]  div_addr;
  logic               start_ok;
  logic               drain_done;

  assign start_ok = start && (state_reg == ST_IDLE);

  // Outbound strobes; the ofifo and peer pulls stop once the row count is reached.
  assign ofifo_rd = (state_reg == ST_ACC) && ofifo_valid && (rd_cnt_reg < rows_reg);
  assign wr_sum   = ((state_reg == ST_ACC) || (state_reg == ST_XCHG)) &&
                    peer_sum_valid && (peer_cnt_reg < rows_reg);
  assign mem_rd   = (state_reg == ST_DIV);
  assign mem_addr = mem_rd ? div_cnt_reg : '0;
  assign sfp_inst = (acc_v ? SFP_ACC : SFP_NOP) | (div_v ? SFP_DIV : SFP_NOP);
  assign busy     = (state_reg != ST_IDLE);

  // In DRAIN no new reads are issued, so an out_wr with the div stage empty is the last row.
  assign drain_done = (state_reg == ST_DRAIN) && out_wr && !div_v;
  assign done       = zero_done_reg | drain_done;

  // ofifo has one cycle of read latency before the row reaches sfp_row.
  sfp_lat_pipe #(.DEPTH(1), .ADDR_W(ADDR_W)) u_acc_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .strobe     (ofifo_rd),
    .addr       (rd_cnt_reg[ADDR_W-1:0]),
    .strobe_dly (acc_v),
    .addr_dly   (acc_idx)
  );

  // psum memory read latency: mem_rd -> div.
  sfp_lat_pipe #(.DEPTH(1), .ADDR_W(ADDR_W)) u_div_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .strobe     (mem_rd),
    .addr       (mem_addr),
    .strobe_dly (div_v),
    .addr_dly   (div_addr)
  );

  // Registered sfp_out: div -> out_wr.
  sfp_lat_pipe #(.DEPTH(1), .ADDR_W(ADDR_W)) u_out_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .strobe     (div_v),
    .addr       (div_addr),
    .strobe_dly (out_wr),
    .addr_dly   (out_addr)
  );

  // Next-state selection for the pass phases.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start && (num_rows != '0)) state_next = ST_ACC;
      ST_ACC:   if (acc_cnt_reg == rows_reg) state_next = ST_XCHG;
      // XCHG is entered at least one cycle after the last acc, so the sum_q -> fifo
      // write has landed by the time the peer count allows the exit.
      ST_XCHG:  if (peer_cnt_reg == rows_reg) state_next = ST_DIV;
      ST_DIV:   if (ROW_W'(div_cnt_reg) == rows_reg - ROW_W'(1)) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register plus pass counters; counters only restart on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      rows_reg      <= '0;
      rd_cnt_reg    <= '0;
      acc_cnt_reg   <= '0;
      peer_cnt_reg  <= '0;
      div_cnt_reg   <= '0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      zero_done_reg <= start_ok && (num_rows == '0);
      if (start_ok) begin
        rows_reg     <= (num_rows > ROWS_CAP) ? ROWS_CAP : num_rows;
        rd_cnt_reg   <= '0;
        acc_cnt_reg  <= '0;
        peer_cnt_reg <= '0;
        div_cnt_reg  <= '0;
      end else begin
        if (ofifo_rd) rd_cnt_reg   <= rd_cnt_reg + ROW_W'(1);
        if (acc_v)    acc_cnt_reg  <= ROW_W'(acc_idx) + ROW_W'(1);
        if (wr_sum)   peer_cnt_reg <= peer_cnt_reg + ROW_W'(1);
        if (mem_rd)   div_cnt_reg  <= div_cnt_reg + ADDR_W'(1);
      end
    end
  end

  // sfp_row must never see acc and div together.
  a_inst_onehot: assert property (@(posedge clk) disable iff (!rstn) (sfp_inst != 2'b11));

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Directed bench for sfp_seq_ctrl: full passes, stalls, early peer sums, zero rows,
// ignored starts, mid-pass reset, clamping.
module tb_sfp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [4:0] num_rows = '0;
  logic       ofifo_valid = 1'b0;
  logic       ofifo_rd;
  logic       peer_sum_valid = 1'b0;
  logic       wr_sum;
  logic [1:0] sfp_inst;
  logic       mem_rd;
  logic [3:0] mem_addr;
  logic       out_wr;
  logic [3:0] out_addr;
  logic       busy;
  logic       done;

  sfp_seq_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .num_rows       (num_rows),
    .ofifo_valid    (ofifo_valid),
    .ofifo_rd       (ofifo_rd),
    .peer_sum_valid (peer_sum_valid),
    .wr_sum         (wr_sum),
    .sfp_inst       (sfp_inst),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .out_wr         (out_wr),
    .out_addr       (out_addr),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [15:0] out_vec;
  assign out_vec = {ofifo_rd, wr_sum, sfp_inst, mem_rd, mem_addr, out_wr, out_addr, busy, done};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Negedge monitor: event counts and latency-relationship error counts per pass.
  logic mon_clear = 1'b0;
  int n_rd, n_acc, n_wr, n_mrd, n_div, n_out, n_done, n_busy;
  int acc_lag_err, div_lag_err, out_lag_err, both_err, maddr_err, oaddr_err;
  int last_out_addr;
  logic prev_rd = 1'b0, prev_mrd = 1'b0, prev_div = 1'b0;

  always @(negedge clk) begin
    if (mon_clear) begin
      n_rd = 0; n_acc = 0; n_wr = 0; n_mrd = 0; n_div = 0; n_out = 0; n_done = 0; n_busy = 0;
      acc_lag_err = 0; div_lag_err = 0; out_lag_err = 0; both_err = 0;
      maddr_err = 0; oaddr_err = 0; last_out_addr = -1;
    end else begin
      if (ofifo_rd) n_rd++;
      if (sfp_inst[0]) n_acc++;
      if (sfp_inst[0] != prev_rd) acc_lag_err++;
      if (wr_sum) n_wr++;
      if (mem_rd) begin
        if (mem_addr != 4'(n_mrd)) maddr_err++;
        n_mrd++;
      end
      if (sfp_inst[1]) n_div++;
      if (sfp_inst[1] != prev_mrd) div_lag_err++;
      if (out_wr) begin
        if (out_addr != 4'(n_out)) oaddr_err++;
        last_out_addr = int'(out_addr);
        n_out++;
      end
      if (out_wr != prev_div) out_lag_err++;
      if (sfp_inst == 2'b11) both_err++;
      if (done) n_done++;
      if (busy) n_busy++;
    end
    prev_rd  = ofifo_rd;
    prev_mrd = mem_rd;
    prev_div = sfp_inst[1];
  end

  task automatic clear_mon();
    ofifo_valid = 1'b0; peer_sum_valid = 1'b0; start = 1'b0;
    mon_clear = 1'b1;
    @(posedge clk); #1;
    mon_clear = 1'b0;
  endtask

  // ofifo_mode: 0 always valid, 1 valid on odd cycles.
  // peer_mode: 0 after ACC (in XCHG), 1 first 5 cycles (during ACC), 2 random.
  // abort_div: extra starts while busy, then rstn low when mem_addr==2.
  task automatic run_pass(input logic [4:0] rows, input int ofifo_mode, input int peer_mode,
                          input bit abort_div);
    int  acc_done_cyc;
    int  rows_eff;
    bit  finished;
    bit  aborted;
    acc_done_cyc = 0; finished = 0; aborted = 0;
    rows_eff = (rows > 5'd16) ? 16 : int'(rows);
    clear_mon();
    num_rows = rows; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (abort_div && mem_rd && mem_addr == 4'd2) begin
        #2 rstn = 1'b0;
        #1;
        check("abort_outputs_zero", 32'(out_vec), 32'd0);
        aborted = 1;
        break;
      end
      ofifo_valid = (ofifo_mode == 0) ? 1'b1 : c[0];
      if (n_acc == rows_eff) acc_done_cyc++;
      case (peer_mode)
        0:       peer_sum_valid = (acc_done_cyc >= 2);
        1:       peer_sum_valid = (c <= 5);
        default: peer_sum_valid = 1'($urandom_range(0, 1));
      endcase
      if (abort_div) begin
        start    = (c == 3) || (c == 9);
        num_rows = 5'd2;
      end
      @(posedge clk); #1;
      if (n_done != 0) begin
        finished = 1;
        break;
      end
    end
    ofifo_valid = 1'b0; peer_sum_valid = 1'b0; start = 1'b0;
    if (aborted) begin
      repeat (3) begin @(posedge clk); #1; end
      check("abort_no_done", n_done, 0);
      check("abort_extra_start_ignored", n_rd, rows_eff);
      check("abort_mem_rd_before_reset", n_mrd, 2);
      rstn = 1'b1;
      @(posedge clk); #1;
    end else if (!finished) begin
      check("pass_timeout", 0, 1);
    end else begin
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(out_vec), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(out_vec), 32'd0);

    // T1: 4 rows, peer words in XCHG
    run_pass(5'd4, 0, 0, 1'b0);
    check("t1_rd", n_rd, 4);
    check("t1_acc", n_acc, 4);
    check("t1_acc_lag", acc_lag_err, 0);
    check("t1_wr_sum", n_wr, 4);
    check("t1_div", n_div, 4);
    check("t1_div_lag", div_lag_err, 0);
    check("t1_mem_addr", maddr_err, 0);
    check("t1_out", n_out, 4);
    check("t1_out_lag", out_lag_err, 0);
    check("t1_out_addr", oaddr_err, 0);
    check("t1_last_out_addr", last_out_addr, 3);
    check("t1_done", n_done, 1);
    check("t1_busy_cycles", n_busy, 17);
    $display("T1 rows=4: rd=%0d acc=%0d wr_sum=%0d div=%0d out=%0d busy=%0d", n_rd, n_acc, n_wr, n_div, n_out, n_busy);

    // T2: 8 rows, ofifo_valid toggling
    run_pass(5'd8, 1, 0, 1'b0);
    check("t2_rd", n_rd, 8);
    check("t2_acc", n_acc, 8);
    check("t2_acc_lag", acc_lag_err, 0);
    check("t2_div", n_div, 8);
    check("t2_done", n_done, 1);
    $display("T2 rows=8 stalled: rd=%0d acc=%0d div=%0d", n_rd, n_acc, n_div);

    // T3: all peer words during ACC, plus an extra one
    run_pass(5'd4, 0, 1, 1'b0);
    check("t3_wr_sum", n_wr, 4);
    check("t3_busy_cycles", n_busy, 13);
    check("t3_div", n_div, 4);
    check("t3_done", n_done, 1);
    $display("T3 early peer: wr_sum=%0d busy=%0d", n_wr, n_busy);

    // T4: zero-row pass
    clear_mon();
    num_rows = 5'd0; start = 1'b1;
    @(negedge clk);
    check("t4_done_cycle0", done, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t4_done_cycle1", done, 1'b1);
    @(negedge clk);
    check("t4_done_cycle2", done, 1'b0);
    @(posedge clk); #1;
    check("t4_busy", n_busy, 0);
    check("t4_activity", n_rd + n_acc + n_div + n_out, 0);
    check("t4_done_count", n_done, 1);
    $display("T4 rows=0: done=%0d busy=%0d", n_done, n_busy);

    // T5: ignored starts, reset in DIV, then a clean pass
    run_pass(5'd4, 0, 0, 1'b1);
    run_pass(5'd3, 0, 0, 1'b0);
    check("t5_rd", n_rd, 3);
    check("t5_div", n_div, 3);
    check("t5_out", n_out, 3);
    check("t5_last_out_addr", last_out_addr, 2);
    check("t5_done", n_done, 1);
    $display("T5 after abort: rd=%0d div=%0d out=%0d done=%0d", n_rd, n_div, n_out, n_done);

    // T6: 16 rows, random peer pattern
    run_pass(5'd16, 0, 2, 1'b0);
    check("t6_div", n_div, 16);
    check("t6_wr_sum", n_wr, 16);
    check("t6_inst_both", both_err, 0);
    check("t6_out_addr", oaddr_err, 0);
    check("t6_last_out_addr", last_out_addr, 15);
    check("t6_done", n_done, 1);
    $display("T6 rows=16: div=%0d wr_sum=%0d last_out_addr=%0d", n_div, n_wr, last_out_addr);

    // T7: oversize request clamps to 16
    run_pass(5'd20, 0, 0, 1'b0);
    check("t7_rd_clamped", n_rd, 16);
    check("t7_div_clamped", n_div, 16);
    check("t7_done", n_done, 1);
    $display("T7 rows=20: rd=%0d div=%0d", n_rd, n_div);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
